// File: rtl/fib_sched_pkg.sv
// fib_sched_pkg: shared types and helpers for the Fibonacci step scheduler.
// Contents: FSM state enum, default field widths, owner-index width function.
package fib_sched_pkg;

    typedef enum logic [1:0] {IDLE, STEP, SETTLE, RESP} state_t;

    localparam int DEF_NREQ   = 2;
    localparam int DEF_CNT_W  = 8;
    localparam int DEF_DATA_W = 8;

    // Owner-index width; never below one bit so a single-bit index still exists.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/fib_sched_if.sv
// fib_sched_if: requester-side job/response handshake bundle.
// Signals: req_valid/req_ready/req_count (job channel, count slice i = [i*CNT_W +: CNT_W]),
//          resp_valid/resp_ready/resp_data (result channel, resp_data shared by all requesters).
// Modports: master = requesters, slave = scheduler.
interface fib_sched_if
    import fib_sched_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*CNT_W-1:0] req_count;
    logic [NREQ-1:0]       resp_valid;
    logic [NREQ-1:0]       resp_ready;
    logic [DATA_W-1:0]     resp_data;

    modport master (
        output req_valid, req_count, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_count, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/fib_sched_arb.sv
// fib_sched_arb: combinational job arbiter for the step scheduler.
// Build option: FIB_SCHED_RR_EN selects round-robin (registered last-grant pointer,
//               reset to NREQ-1); otherwise fixed priority with the lowest index winning.
// Ports: clk, rst_n, i_accept (RR build only; i_accept advances the pointer),
//        i_req_valid (pending jobs), o_grant (winner index), o_any (some job pending).
module fib_sched_arb
    import fib_sched_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int OW   = clog2(NREQ)
) (
`ifdef FIB_SCHED_RR_EN
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_accept,
`endif
    input  logic [NREQ-1:0] i_req_valid,
    output logic [OW-1:0]   o_grant,
    output logic            o_any
);

`ifdef FIB_SCHED_RR_EN
    logic [OW-1:0] r_last;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            r_last <= OW'(NREQ - 1);
        else if (i_accept)
            r_last <= o_grant;

    // Lowest requester above the pointer wins; if none, wrap to the lowest one at or below it.
    always_comb begin
        o_grant = '0;
        o_any   = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (i_req_valid[i] && OW'(i) <= r_last) begin
                o_grant = OW'(i);
                o_any   = 1'b1;
            end
        for (int i = NREQ - 1; i >= 0; i--)
            if (i_req_valid[i] && OW'(i) > r_last) begin
                o_grant = OW'(i);
                o_any   = 1'b1;
            end
    end
`else
    always_comb begin
        o_grant = '0;
        o_any   = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (i_req_valid[i]) begin
                o_grant = OW'(i);
                o_any   = 1'b1;
            end
    end
`endif

endmodule

// File: rtl/fib_step_scheduler.sv
// fib_step_scheduler: shares one Fibonacci step datapath between NREQ requesters.
// A granted job pulses o_step for exactly its count, captures i_dp_out one cycle later
// and returns it on the owner's response channel.
// Build option: FIB_SCHED_RR_EN (round-robin arbitration, see fib_sched_arb).
// Ports: clk, rst_n (async active-low), io_bus (fib_sched_if.slave job/response bundle),
//        i_dp_out (datapath output), o_step (datapath step enable), o_busy (job in flight).
module fib_step_scheduler
    import fib_sched_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    fib_sched_if.slave        io_bus,
    input  logic [DATA_W-1:0] i_dp_out,
    output logic              o_step,
    output logic              o_busy
);
    localparam int OW = clog2(NREQ);

    state_t             r_state;
    state_t             w_next;
    logic [OW-1:0]      r_owner;
    logic [CNT_W-1:0]   r_remaining;
    logic [DATA_W-1:0]  r_result;
    logic [OW-1:0]      w_grant;
    logic               w_any;
    logic               w_accept;
    logic [CNT_W-1:0]   w_count;

    fib_sched_arb #(.NREQ(NREQ)) u_arb (
`ifdef FIB_SCHED_RR_EN
        .clk         (clk),
        .rst_n       (rst_n),
        .i_accept    (w_accept),
`endif
        .i_req_valid (io_bus.req_valid),
        .o_grant     (w_grant),
        .o_any       (w_any)
    );

    assign w_accept         = (r_state == IDLE) && w_any;
    assign w_count          = io_bus.req_count[int'(w_grant) * CNT_W +: CNT_W];
    assign io_bus.resp_data = r_result;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;

    always_comb begin
        w_next            = r_state;
        o_step            = 1'b0;
        o_busy            = (r_state != IDLE);
        io_bus.req_ready  = '0;
        io_bus.resp_valid = '0;
        case (r_state)
            IDLE:
                if (w_any) begin
                    io_bus.req_ready = NREQ'(1) << w_grant;
                    w_next           = (w_count == '0) ? SETTLE : STEP;
                end
            STEP: begin
                o_step = 1'b1;
                w_next = (r_remaining == CNT_W'(1)) ? SETTLE : STEP;
            end
            SETTLE:
                w_next = RESP;
            RESP: begin
                io_bus.resp_valid = NREQ'(1) << r_owner;
                w_next            = io_bus.resp_ready[r_owner] ? IDLE : RESP;
            end
            default:
                w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_owner     <= '0;
            r_remaining <= '0;
            r_result    <= '0;
        end else begin
            if (w_accept) begin
                r_owner     <= w_grant;
                r_remaining <= w_count;
            end else if (r_state == STEP)
                r_remaining <= r_remaining - CNT_W'(1);
            if (r_state == SETTLE)
                r_result <= i_dp_out;
        end

endmodule

// File: tb/tb_fib_step_scheduler.sv
// tb_fib_step_scheduler: randomized self-checking bench for fib_step_scheduler.
// Drives a Fibonacci datapath from o_step and predicts every result as F(total steps) mod 2^8.
module tb_fib_step_scheduler;
    localparam int NREQ   = 2;
    localparam int CNT_W  = 8;
    localparam int DATA_W = 8;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic dp_rst_n = 1'b0;
    logic step;
    logic busy;
    logic [DATA_W-1:0] dp_a;
    logic [DATA_W-1:0] dp_b;

    int n_checks    = 0;
    int n_fail      = 0;
    int total_steps = 0;
    int rr_last     = NREQ - 1;

    always #5 clk = ~clk;

    fib_sched_if #(.NREQ(NREQ), .CNT_W(CNT_W), .DATA_W(DATA_W)) bus ();

    fib_step_scheduler #(.NREQ(NREQ), .CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .io_bus   (bus),
        .i_dp_out (dp_a),
        .o_step   (step),
        .o_busy   (busy)
    );

    always_ff @(posedge clk or negedge dp_rst_n)
        if (!dp_rst_n) begin
            dp_a <= '0;
            dp_b <= 8'd1;
        end else if (step) begin
            dp_a <= dp_b;
            dp_b <= dp_a + dp_b;
        end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int fib_mod(input int n);
        int x, y, t;
        x = 0;
        y = 1;
        repeat (n) begin
            t = (x + y) % 256;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic int pick(input logic [NREQ-1:0] v);
`ifdef FIB_SCHED_RR_EN
        for (int k = 1; k <= NREQ; k++)
            if (v[(rr_last + k) % NREQ]) return (rr_last + k) % NREQ;
`else
        for (int k = 0; k < NREQ; k++)
            if (v[k]) return k;
`endif
        return 0;
    endfunction

    // Entered and left at posedge+1; the new request is presented in the cycle right after any handshake.
    task automatic run_job(input logic [NREQ-1:0] v, input logic [NREQ*CNT_W-1:0] c, input int hold, output int w);
        int n, k;
        logic [DATA_W-1:0] d0;
        bus.req_valid = v;
        bus.req_count = c;
        w = pick(v);
        n = int'(c[w*CNT_W +: CNT_W]);
        k = 0;
        @(negedge clk);
        check("resp_clear", bus.resp_valid, 0);
        while (bus.req_ready == '0 && k < 20) begin
            @(posedge clk); #1;
            @(negedge clk);
            k++;
        end
        check("accept", bus.req_ready, 1 << w);
        check("idle_step", step, 0);
        check("idle_busy", busy, 0);
        rr_last = w;
        for (k = 1; k <= n + 6; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (bus.resp_valid != '0) break;
            check("step_win", step, k <= n);
            check("no_ready", bus.req_ready, 0);
            check("busy", busy, 1);
        end
        check("latency", k, n + 2);
        check("resp_valid", bus.resp_valid, 1 << w);
        total_steps += n;
        check("resp_data", bus.resp_data, fib_mod(total_steps));
        d0 = bus.resp_data;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            bus.resp_ready = NREQ'($urandom) & ~(NREQ'(1) << w);
            @(negedge clk);
            check("hold_valid", bus.resp_valid, 1 << w);
            check("hold_data", bus.resp_data, d0);
            check("hold_ready", bus.req_ready, 0);
        end
        @(posedge clk); #1;
        bus.resp_ready = NREQ'(1) << w;
        @(posedge clk); #1;
        bus.resp_ready = '0;
    endtask

    initial begin
        int w;
        logic [NREQ-1:0] v;
        logic [NREQ*CNT_W-1:0] c;
        bus.req_valid  = '0;
        bus.req_count  = '0;
        bus.resp_ready = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_step", step, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_data", bus.resp_data, 0);
        @(posedge clk); #1;
        rst_n    = 1'b1;
        dp_rst_n = 1'b1;
        @(posedge clk); #1;
        run_job(2'b01, {8'd0, 8'd3}, 0, w);
        run_job(2'b10, {8'd0, 8'd0}, 0, w);
        repeat (4) run_job(2'b11, {8'd2, 8'd2}, 0, w);
        run_job(2'b11, {8'd5, 8'd4}, 10, w);
        run_job(2'b01, {8'd0, 8'd255}, 1, w);
        repeat (24) begin
            v = NREQ'($urandom_range(1, 3));
            c = {CNT_W'($urandom_range(0, 12)), CNT_W'($urandom_range(0, 12))};
            run_job(v, c, int'($urandom_range(0, 3)), w);
        end
        bus.req_valid = 2'b01;
        bus.req_count = {8'd0, 8'd200};
        @(negedge clk);
        check("rst_job_accept", bus.req_ready, 1);
        repeat (50) @(posedge clk);
        #2;
        check("pre_rst_step", step, 1);
        bus.req_valid = '0;
        rst_n         = 1'b0;
        dp_rst_n      = 1'b0;
        #1;
        check("async_step", step, 0);
        check("async_busy", busy, 0);
        check("async_resp", bus.resp_valid, 0);
        check("async_ready", bus.req_ready, 0);
        rr_last     = NREQ - 1;
        total_steps = 0;
        @(posedge clk); #1;
        rst_n    = 1'b1;
        dp_rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("dropped_busy", busy, 0);
            check("dropped_resp", bus.resp_valid, 0);
        end
        @(posedge clk); #1;
        run_job(2'b11, {8'd1, 8'd3}, 2, w);
        run_job(2'b10, {8'd6, 8'd0}, 0, w);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fib_step_scheduler.md
# fib_step_scheduler

Shares one Fibonacci-style step datapath between NREQ requesters. Each requester submits a job: advance the datapath N times, then return its 8-bit output. The scheduler arbitrates between pending jobs and drives the datapath's 1-bit step input for exactly N cycles. It then samples the datapath output and returns it on the granted requester's response channel. It sits between the requester ports and the generated stepper core, and is the only driver of the stepper's step input.

## Interface
- NREQ, 2, number of requesters (2..4)
- CNT_W, 8, width of step-count field
- DATA_W, 8, width of datapath output and response data
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- req_valid  input  NREQ  per-requester job valid
- req_ready  output  NREQ  per-requester job accepted; reset 0
- req_count  input  NREQ*CNT_W  per-requester step count, slice i = [i*CNT_W +: CNT_W]
- resp_valid  output  NREQ  per-requester result valid; reset 0
- resp_ready  input  NREQ  per-requester result accepted
- resp_data  output  DATA_W  result, shared bus, meaningful for the asserted resp_valid bit; reset 0
- step_o  output  1  step enable to datapath; reset 0
- dp_out_i  input  DATA_W  datapath output
- busy  output  1  job in progress (state != IDLE); reset 0

## Operation
- FSM states: IDLE, STEP, SETTLE, RESP.
- IDLE:
  - If any req_valid is set, the arbiter picks winner w. req_ready[w] pulses for 1 cycle.
  - The scheduler latches the owner index and count.
  - count = 0: go to SETTLE, no step pulses.
  - count > 0: go to STEP with remaining = count.
- STEP:
  - step_o = 1.
  - remaining decrements each cycle.
  - When remaining = 1, go to SETTLE next cycle.
  - step_o is high for exactly count cycles.
- SETTLE:
  - step_o = 0.
  - dp_out_i is captured into the result register.
  - Go to RESP.
- RESP:
  - resp_valid[owner] = 1 and resp_data = captured value.
  - Both hold stable until resp_ready[owner].
  - On handshake, go to IDLE.
  - resp_ready on other bits is ignored.
- Only one job is in flight. req_ready is never asserted outside IDLE.
- A requester may hold req_valid through its own response. It is re-arbitrated on the IDLE cycle after the handshake.
- Counter is CNT_W bits, unsigned. Max job is 2^CNT_W−1 steps. No wrap inside a job.
- The datapath is never reset by this block. Results depend on all steps issued since datapath reset.

## Timing
- Job accepted in cycle t (IDLE, req_ready high).
- step_o is high in cycles t+1..t+N.
- Capture happens in cycle t+N+1.
- resp_valid rises in cycle t+N+2.
- Minimum latency from accept to resp_valid is N+2. For N = 0 it is 2.
- Back-to-back throughput: the next accept is no earlier than the cycle after the response handshake.
- Reset asserted mid-job:
  - Asynchronously clears state to IDLE, step_o/req_ready/resp_valid/busy to 0, and counters and result to 0.
  - Any in-flight job is dropped without a response.
- Ties (several req_valid in IDLE) are resolved by the arbiter in the same cycle. There is no extra latency.

## Configuration
- FIB_SCHED_RR_EN defined:
  - Round-robin arbitration.
  - The last-granted pointer updates on each accept. The search starts at last+1 mod NREQ.
  - Pointer resets to NREQ−1, so requester 0 wins first.
- Undefined:
  - Fixed priority, lowest index wins.
  - No pointer register.

## Structure
- Package fib_sched_pkg:
  - State enum (IDLE, STEP, SETTLE, RESP).
  - Default CNT_W/DATA_W localparams.
  - Owner-index width function clog2(NREQ).
- Sub-module fib_sched_arb: combinational grant from req_valid plus optional registered RR pointer, under FIB_SCHED_RR_EN.
- Top-level fib_step_scheduler holds the FSM, counter, result register and response muxing.

## Test plan
- Single job: req0 count=3 after reset → req_ready[0] 1 cycle. step_o high exactly 3 consecutive cycles. resp_valid[0] at accept+5 with resp_data = dp_out_i value seen in SETTLE cycle.
- Zero count: req1 count=0 → no step_o pulse, resp_valid[1] at accept+2.
- Simultaneous requests, count=2 each, with RR:
  - Grant order is 0, 1, 0, 1 across four jobs.
  - Without macro: order is 0, 0, 0 while req0 is held.
- Backpressure: resp_ready[0] held low 10 cycles → resp_valid[0] and resp_data stable. No req_ready for a waiting req1 until the handshake completes.
- Reset mid-STEP: count=200, rst low at step 50 → step_o, busy and resp_valid are 0 immediately (asynchronous). After release the FSM is in IDLE with no response for the dropped job.
- Max count: count=255 → exactly 255 step_o cycles, counter does not wrap, resp_valid at accept+257.
